// File: rtl/mux4_rr_arbiter_if.sv
// Request/grant bundle between four requesters and the shared-mux arbiter.
// Handshake: a requester holds req[i] until it sees gnt[i]; the grant persists while req[i] stays high, up to MAX_HOLD cycles.
interface mux4_rr_arbiter_if #(
  parameter int MAX_HOLD = 8
);
  localparam int CNT_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

  logic [3:0]       req;
  logic [3:0]       gnt;
  logic [1:0]       sel;
  logic             sel_valid;
  logic [CNT_W-1:0] tenure;
  logic             state_dbg;   // 1 while an owner holds the grant

  modport master (
    output req,
    input  gnt, sel, sel_valid, tenure, state_dbg
  );

  modport slave (
    input  req,
    output gnt, sel, sel_valid, tenure, state_dbg
  );
endinterface

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter driving the select of a shared 4:1 mux, with a bounded
// grant tenure. All outputs are registered; no combinational req-to-output path.
module mux4_rr_arbiter #(
  parameter int MAX_HOLD = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  mux4_rr_arbiter_if.slave  bus
);
  localparam int CNT_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [CNT_W-1:0] TEN_MAX = CNT_W'(MAX_HOLD - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state_q;
  logic [3:0]       gnt_q;
  logic [1:0]       sel_q;
  logic             sel_valid_q;
  logic [CNT_W-1:0] tenure_q;
  logic [1:0]       ptr_q;

  logic             rel;
  logic [1:0]       base;
  logic [1:0]       win;
  logic             found;

  // On release the search already uses the advanced pointer, so the handover
  // to the next owner happens at the same edge with no idle cycle.
  always_comb begin
    rel   = (state_q == GRANT) && (!bus.req[sel_q] || (tenure_q == TEN_MAX));
    base  = rel ? (sel_q + 2'd1) : ptr_q;
    found = 1'b0;
    win   = base;
    for (int k = 3; k >= 0; k--) begin
      if (bus.req[base + 2'(k)]) begin
        found = 1'b1;
        win   = base + 2'(k);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      gnt_q       <= 4'b0000;
      sel_q       <= 2'd0;
      sel_valid_q <= 1'b0;
      tenure_q    <= '0;
      ptr_q       <= 2'd0;
    end else begin
      case (state_q)
        IDLE: begin
          tenure_q <= '0;
          if (found) begin
            state_q     <= GRANT;
            gnt_q       <= 4'b0001 << win;
            sel_q       <= win;
            sel_valid_q <= 1'b1;
          end
        end
        GRANT: begin
          if (rel) begin
            ptr_q    <= sel_q + 2'd1;
            tenure_q <= '0;
            if (found) begin
              gnt_q <= 4'b0001 << win;
              sel_q <= win;
            end else begin
              // sel is left as-is; it is meaningless while sel_valid is low
              state_q     <= IDLE;
              gnt_q       <= 4'b0000;
              sel_valid_q <= 1'b0;
            end
          end else begin
            tenure_q <= tenure_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.sel       = sel_q;
  assign bus.sel_valid = sel_valid_q;
  assign bus.tenure    = tenure_q;
  assign bus.state_dbg = (state_q == GRANT);
endmodule

// File: doc/mux4_rr_arbiter.md
Name: mux4_rr_arbiter

Overview:
Round-robin arbiter that shares the 4:1 mux datapath (mux4x1) between four requesters. It drives the mux select lines so that exactly one requester's input reaches the output at a time. Each grant lasts until the owner drops its request or a maximum tenure expires. It sits directly in front of mux4x1 and feeds its Sel input; one instance is used per shared mux.

Parameters:
MAX_HOLD, 8, maximum consecutive cycles one requester may hold a grant; legal range 1..256.
CNT_W, $clog2(MAX_HOLD) (minimum 1), width of the tenure counter; derived, not overridden.

Ports:
clk  input  1  system clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
req  input  4  request per requester; bit i = requester i (i=0 maps to mux input A … i=3 to D)
gnt  output  4  one-hot grant; all zero when no owner
sel  output  2  binary index of current owner; drives mux4x1 Sel
sel_valid  output  1  high when gnt is non-zero; sel is meaningful only when high
tenure  output  CNT_W  cycles the current owner has held the grant, 0-based

Behaviour:
- Reset (rst_n low, asynchronous, takes effect without a clock edge): gnt=4'b0000, sel=2'd0, sel_valid=0, tenure=0, internal priority pointer ptr=2'd0, state=IDLE. Release is synchronous: the first active edge after rst_n goes high evaluates req normally.
- All outputs are registered. There is no combinational path from req to any output.
- Priority search: starting at index ptr and wrapping modulo 4, the first index with req set wins. Examples: ptr=2, req=4'b1011 -> winner 3; ptr=3, req=4'b0011 -> winner 0.
- State IDLE (gnt=0):
  - If any req bit is set at an edge, go to GRANT with owner = search winner.
  - gnt/sel/sel_valid update at that same edge, so the grant is visible one cycle after req is first sampled.
  - tenure=0.
  - If req=0, stay in IDLE.
- State GRANT (owner o, gnt=1<<o, sel=o, sel_valid=1):
  - Release condition at an edge: req[o]==0, or tenure==MAX_HOLD-1.
  - No release: tenure increments (saturation never needed, given the release rule).
  - Release: ptr <= (o+1) mod 4. The search is then evaluated at the same edge using the new ptr value and the current req.
    - Winner found: go back-to-back to the new owner with no bubble cycle, and tenure resets to 0.
    - No request: go to IDLE, and gnt/sel_valid clear.
  - sel holds its last value in IDLE; it is don't-care and is not cleared.
- Fairness:
  - On timeout with req[o] still high, o is lowest priority. It is re-granted only if no other req bit is set, and then gets a fresh tenure of 0.
  - Worst-case wait for a continuously requesting input is 3*MAX_HOLD cycles plus 1.
- MAX_HOLD=1: every grant lasts exactly one cycle, so arbitration rotates every cycle while requests persist.
- Requests that rise and fall between edges are never seen. Requesters must hold req until they observe their gnt bit.
- Dropping req while granted releases the grant at the next edge; the owner loses it one cycle after deassertion.
- Invariants (assertable):
  - gnt is zero or one-hot.
  - sel_valid == |gnt.
  - When sel_valid=1, gnt == 1<<sel.
  - tenure <= MAX_HOLD-1.

Test Plan:
- Reset mid-grant: owner 2 at tenure 3; pulse rst_n low between edges -> gnt=0, sel_valid=0, tenure=0 immediately without a clock edge. After release with req=4'b0100, the grant goes to 2, since ptr was reset to 0.
- Single requester: req=4'b0001 from cycle 0 -> gnt=4'b0001, sel=0 from cycle 1. Drop req at cycle 5 -> gnt=0 at cycle 6.
- All request, MAX_HOLD=8: req=4'b1111 held -> owners 0,1,2,3,0 in successive 8-cycle windows. Back-to-back handover with no gnt=0 cycle; tenure 0..7 in each window.
- Timeout, lone requester: req=4'b0010 held for 20 cycles -> gnt stays 4'b0010 continuously; tenure runs 0..7, 0..7, 0..3.
- Pointer wrap: grant to 3 released with req=4'b1001 -> next owner 0 (ptr=0). Then release 0 with req=4'b1000 -> owner 3.
- Early release plus new arrival: owner 1 drops req at tenure 2 while req[3] rises in the same cycle -> next edge gnt=4'b1000, sel=3, tenure=0.
